// File: rtl/i2c_tx_byte_controller_pkg.sv
// Shared I2C byte-controller definitions: state and step encodings, bit count.
// Used by both the transmit and receive byte controllers.
package i2c_pkg;

    localparam int TOTAL_BITS = 8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_BIT1 = 4'd1,
        ST_BIT2 = 4'd2,
        ST_BIT3 = 4'd3,
        ST_BIT4 = 4'd4,
        ST_BIT5 = 4'd5,
        ST_BIT6 = 4'd6,
        ST_BIT7 = 4'd7,
        ST_BIT8 = 4'd8,
        ST_ACK  = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        STEP_DRIVE  = 2'd0,
        STEP_SCL_HI = 2'd1,
        STEP_WAIT   = 2'd2,
        STEP_SCL_LO = 2'd3
    } step_e;

    function automatic logic is_bit_state(input state_e s);
        return (s >= ST_BIT1) && (s <= ST_BIT8);
    endfunction

endpackage

// File: rtl/i2c_tx_byte_controller_stretch_timer.sv
// Tick counter for SCL clock-stretch supervision. Counts enabled ticks and
// pulses o_timeout on the LIMIT-th one; LIMIT = 0 never times out.
module i2c_stretch_timer #(
    parameter int LIMIT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout
);

    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? (LIMIT - 1) : 0);

    logic [CNT_W-1:0] cnt_q;

    assign o_timeout = (LIMIT != 0) && i_en && (cnt_q == LAST);

    // Count stretched ticks, saturating at the terminal value; clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_tx_byte_controller.sv
// I2C master byte transmitter: 8 data bits MSB-first, then ACK sample on the
// 9th SCL pulse. Paced by i_tick, honours slave clock stretching.
// Optional macro I2C_TX_ARB_DETECT_EN adds arbitration-loss detection.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | SCL held low (or released after error), waiting for start
// BIT1..8 | drive data bit, raise SCL, wait for SCL high, lower SCL
// ACK     | release SDA, raise SCL, sample slave ACK, lower SCL
module i2c_tx_byte_controller
    import i2c_pkg::*;
#(
    parameter int STRETCH_TIMEOUT = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_tx_done,
    output logic       o_ack,
    output logic       o_tx_error,
    output logic       o_busy,
    output logic       o_sda_disable,
    output logic       o_scl_disable,
    output logic       o_sda,
    output logic       o_scl
);

    state_e                  state_q;
    step_e                   step_q;
    logic [TOTAL_BITS-1:0]   shift_q;
    logic                    sda_q;
    logic                    scl_q;
    logic                    done_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    release_q;   // lines left released in IDLE after an abort

    logic in_wait;
    logic stretch_timeout;
    logic arb_lost;

    assign in_wait = (is_bit_state(state_q) || (state_q == ST_ACK)) && (step_q == STEP_WAIT);

    i2c_stretch_timer #(
        .LIMIT(STRETCH_TIMEOUT)
    ) u_stretch_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (in_wait && i_tick && !i_scl),
        .i_clr    (!in_wait),
        .o_timeout(stretch_timeout)
    );

`ifdef I2C_TX_ARB_DETECT_EN
    // We released SDA high but the line reads low: another master won.
    assign arb_lost = is_bit_state(state_q) && (step_q == STEP_WAIT) && i_tick
                      && i_scl && shift_q[TOTAL_BITS-1] && !i_sda;
`else
    assign arb_lost = 1'b0;
`endif

    // Byte sequencer: one step per tick, all line and status outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= STEP_DRIVE;
            shift_q   <= '0;
            sda_q     <= 1'b1;
            scl_q     <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            release_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sda_q  <= 1'b1;
                    scl_q  <= 1'b0;
                    step_q <= STEP_DRIVE;
                    if (i_tx_start) begin
                        shift_q   <= i_tx_data;
                        ack_q     <= 1'b0;
                        release_q <= 1'b0;
                        state_q   <= ST_BIT1;
                    end
                end
                ST_BIT1, ST_BIT2, ST_BIT3, ST_BIT4,
                ST_BIT5, ST_BIT6, ST_BIT7, ST_BIT8, ST_ACK: begin
                    if (i_tick) begin
                        case (step_q)
                            STEP_DRIVE: begin
                                sda_q  <= (state_q == ST_ACK) ? 1'b1 : shift_q[TOTAL_BITS-1];
                                step_q <= STEP_SCL_HI;
                            end
                            STEP_SCL_HI: begin
                                scl_q  <= 1'b1;
                                step_q <= STEP_WAIT;
                            end
                            STEP_WAIT: begin
                                if (arb_lost || stretch_timeout) begin
                                    err_q     <= 1'b1;
                                    release_q <= 1'b1;
                                    sda_q     <= 1'b1;
                                    scl_q     <= 1'b0;
                                    step_q    <= STEP_DRIVE;
                                    state_q   <= ST_IDLE;
                                end else if (i_scl) begin
                                    if (state_q == ST_ACK) begin
                                        ack_q <= ~i_sda;
                                    end
                                    step_q <= STEP_SCL_LO;
                                end
                            end
                            STEP_SCL_LO: begin
                                scl_q  <= 1'b0;
                                step_q <= STEP_DRIVE;
                                if (state_q == ST_ACK) begin
                                    done_q  <= 1'b1;
                                    state_q <= ST_IDLE;
                                end else begin
                                    shift_q <= {shift_q[TOTAL_BITS-2:0], 1'b0};
                                    state_q <= state_e'(state_q + 4'd1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    step_q  <= STEP_DRIVE;
                end
            endcase
        end
    end

    assign o_sda         = sda_q;
    assign o_scl         = scl_q;
    assign o_tx_done     = done_q;
    assign o_ack         = ack_q;
    assign o_tx_error    = err_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_sda_disable = !is_bit_state(state_q);
    assign o_scl_disable = (state_q == ST_IDLE) ? release_q : scl_q;

endmodule

// File: tb/tb_i2c_tx_byte_controller.sv
// Directed bench for i2c_tx_byte_controller with an open-drain bus model,
// an ACKing slave, SCL stretching and a competing SDA driver.
module tb_i2c_tx_byte_controller;

    localparam int TO = 15;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_tx_start = 1'b0;
    logic [7:0] i_tx_data = 8'h00;
    logic       i_scl;
    logic       i_sda;
    logic       o_tx_done, o_ack, o_tx_error, o_busy;
    logic       o_sda_disable, o_scl_disable, o_sda, o_scl;

    logic       scl_hold = 1'b0;
    logic       other_pull = 1'b0;
    logic       slave_pull = 1'b0;
    bit         ack_en = 1'b0;
    int         base = 0;

    int         tick_total = 0;
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [8:0] rx_bits = 9'h0;
    logic       scl_prev = 1'b0;

    int checks = 0;
    int failures = 0;

    assign i_scl = !((!o_scl_disable && !o_scl) || scl_hold);
    assign i_sda = !((!o_sda_disable && !o_sda) || slave_pull || other_pull);

    i2c_tx_byte_controller #(.STRETCH_TIMEOUT(TO)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_tick),
        .i_tx_start   (i_tx_start),
        .i_tx_data    (i_tx_data),
        .i_scl        (i_scl),
        .i_sda        (i_sda),
        .o_tx_done    (o_tx_done),
        .o_ack        (o_ack),
        .o_tx_error   (o_tx_error),
        .o_busy       (o_busy),
        .o_sda_disable(o_sda_disable),
        .o_scl_disable(o_scl_disable),
        .o_sda        (o_sda),
        .o_scl        (o_scl)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge i_clk);
            i_tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    // Bus monitor and slave: SDA sampled on SCL rise, slave pulls SDA for the ACK slot.
    always @(posedge i_clk) begin
        if (i_tick) tick_total <= tick_total + 1;
        if (o_tx_done) done_cnt <= done_cnt + 1;
        if (o_tx_error) err_cnt <= err_cnt + 1;
        scl_prev <= i_scl;
        if (i_scl && !scl_prev) begin
            rx_cnt  <= rx_cnt + 1;
            rx_bits <= {rx_bits[7:0], i_sda};
        end
        if (!i_scl && scl_prev) slave_pull <= ack_en && ((rx_cnt - base) == 8);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // sbit: 1..9 = state whose step2 is stretched (0 none); sticks < 0 holds forever.
    task automatic run_byte(input logic [7:0] d, input bit ack_i, input int sbit,
                            input int sticks, input bit arb,
                            output int ticks, output bit ended_done, output bit ended_err);
        int  t0, t_hold, hs;
        bit  fin;
        ack_en = ack_i;
        @(negedge i_clk);
        i_tx_data  = d;
        i_tx_start = 1'b1;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        base       = rx_cnt;
        t0         = tick_total;
        other_pull = arb;
        hs  = (sbit > 0) ? 0 : 3;
        fin = 1'b0;
        t_hold = 0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge i_clk);
            if (other_pull && (rx_cnt - base) >= 1 && !i_scl) other_pull = 1'b0;
            case (hs)
                0: if ((rx_cnt - base) == sbit - 1 && !i_scl) begin scl_hold = 1'b1; hs = 1; end
                1: if (o_scl_disable) begin t_hold = tick_total; hs = 2; end
                2: if (sticks >= 0 && (tick_total - t_hold) >= sticks) begin scl_hold = 1'b0; hs = 3; end
                default: ;
            endcase
            if (o_tx_done || o_tx_error) fin = 1'b1;
        end
        check("wait_budget", 32'(fin), 32'd1);
        ticks      = tick_total - t0;
        ended_done = o_tx_done;
        ended_err  = o_tx_error;
        other_pull = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         sbit;
        int         sticks;
        logic [7:0] exp_bits;
        int         exp_ticks;
        bit         exp_ack;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int  tk, dc0, ec0;
        bit  dn, er, seen, fired;

        tbl[0] = '{8'hA5, 1'b1, 0, 0,  8'hA5, 36, 1'b1};
        tbl[1] = '{8'h3C, 1'b0, 0, 0,  8'h3C, 36, 1'b0};
        tbl[2] = '{8'h96, 1'b1, 3, 10, 8'h96, 46, 1'b1};
        tbl[3] = '{8'h00, 1'b1, 0, 0,  8'h00, 36, 1'b1};
        tbl[4] = '{8'hFF, 1'b0, 8, 4,  8'hFF, 40, 1'b0};
        tbl[5] = '{8'h5A, 1'b1, 9, 3,  8'h5A, 39, 1'b1};

        repeat (3) @(negedge i_clk);
        check("rst_sda", 32'(o_sda), 32'd1);
        check("rst_scl", 32'(o_scl), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_tx_done), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_err", 32'(o_tx_error), 32'd0);
        check("rst_sda_dis", 32'(o_sda_disable), 32'd1);
        check("rst_scl_dis", 32'(o_scl_disable), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        for (int v = 0; v < 6; v++) begin
            dc0 = done_cnt;
            ec0 = err_cnt;
            run_byte(tbl[v].data, tbl[v].ack, tbl[v].sbit, tbl[v].sticks, 1'b0, tk, dn, er);
            check($sformatf("v%0d_ticks", v), 32'(tk), 32'(tbl[v].exp_ticks));
            check($sformatf("v%0d_done", v), 32'(dn), 32'd1);
            check($sformatf("v%0d_err", v), 32'(er), 32'd0);
            repeat (2) @(negedge i_clk);
            check($sformatf("v%0d_bits", v), 32'(rx_bits[8:1]), 32'(tbl[v].exp_bits));
            check($sformatf("v%0d_ack", v), 32'(o_ack), 32'(tbl[v].exp_ack));
            check($sformatf("v%0d_busy", v), 32'(o_busy), 32'd0);
            check($sformatf("v%0d_done_cnt", v), 32'(done_cnt - dc0), 32'd1);
            check($sformatf("v%0d_err_cnt", v), 32'(err_cnt - ec0), 32'd0);
        end

        // Start held through done: busy start ignored, then accepted on the next IDLE cycle.
        ack_en = 1'b1;
        @(negedge i_clk);
        i_tx_data  = 8'h0F;
        i_tx_start = 1'b1;
        @(negedge i_clk);
        base      = rx_cnt;
        i_tx_data = 8'hC3;
        seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk);
            if (o_tx_done) begin seen = 1'b1; break; end
        end
        check("chain_first_done", 32'(seen), 32'd1);
        check("chain_first_bits", 32'(rx_bits[8:1]), 32'h0F);
        check("chain_idle_at_done", 32'(o_busy), 32'd0);
        base = rx_cnt;
        @(negedge i_clk);
        check("chain_accept_next", 32'(o_busy), 32'd1);
        i_tx_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk);
            if (o_tx_done) begin seen = 1'b1; break; end
        end
        check("chain_second_done", 32'(seen), 32'd1);
        repeat (2) @(negedge i_clk);
        check("chain_second_bits", 32'(rx_bits[8:1]), 32'hC3);
        check("chain_second_ack", 32'(o_ack), 32'd1);

        // Stretch timeout: SCL held low forever in BIT5.
        dc0 = done_cnt;
        ec0 = err_cnt;
        run_byte(8'hE7, 1'b1, 5, -1, 1'b0, tk, dn, er);
        check("to_err", 32'(er), 32'd1);
        check("to_done", 32'(dn), 32'd0);
        check("to_ticks", 32'(tk), 32'd33);
        check("to_busy", 32'(o_busy), 32'd0);
        check("to_sda_dis", 32'(o_sda_disable), 32'd1);
        check("to_scl_dis", 32'(o_scl_disable), 32'd1);
        scl_hold = 1'b0;
        repeat (3) @(negedge i_clk);
        check("to_err_pulse", 32'(o_tx_error), 32'd0);
        check("to_err_cnt", 32'(err_cnt - ec0), 32'd1);
        check("to_done_cnt", 32'(done_cnt - dc0), 32'd0);

        // Mid-byte start with 0x55 is ignored; reset in BIT6 aborts silently.
        ack_en = 1'b1;
        @(negedge i_clk);
        i_tx_data  = 8'hFF;
        i_tx_start = 1'b1;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        base  = rx_cnt;
        fired = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk);
            if (!fired && (rx_cnt - base) == 2) begin
                i_tx_data  = 8'h55;
                i_tx_start = 1'b1;
                fired = 1'b1;
            end else begin
                i_tx_start = 1'b0;
            end
            if ((rx_cnt - base) == 5 && !i_scl) begin seen = 1'b1; break; end
        end
        check("mr_reached_bit6", 32'(seen), 32'd1);
        check("mr_bits_1to5", 32'(rx_bits[4:0]), 32'h1F);
        dc0 = done_cnt;
        ec0 = err_cnt;
        i_rst_n = 1'b0;
        #1;
        check("mr_sda", 32'(o_sda), 32'd1);
        check("mr_scl", 32'(o_scl), 32'd0);
        check("mr_busy", 32'(o_busy), 32'd0);
        check("mr_done", 32'(o_tx_done), 32'd0);
        check("mr_err", 32'(o_tx_error), 32'd0);
        repeat (3) @(negedge i_clk);
        check("mr_done_cnt", 32'(done_cnt - dc0), 32'd0);
        check("mr_err_cnt", 32'(err_cnt - ec0), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Another master pulls SDA low during BIT1 while 0x80 is sent.
        dc0 = done_cnt;
        ec0 = err_cnt;
        run_byte(8'h80, 1'b1, 0, 0, 1'b1, tk, dn, er);
`ifdef I2C_TX_ARB_DETECT_EN
        check("arb_err", 32'(er), 32'd1);
        check("arb_done", 32'(dn), 32'd0);
        check("arb_ticks", 32'(tk), 32'd3);
        check("arb_sda_dis", 32'(o_sda_disable), 32'd1);
        check("arb_scl_dis", 32'(o_scl_disable), 32'd1);
        repeat (3) @(negedge i_clk);
        check("arb_done_cnt", 32'(done_cnt - dc0), 32'd0);
`else
        check("arb_err", 32'(er), 32'd0);
        check("arb_done", 32'(dn), 32'd1);
        check("arb_ticks", 32'(tk), 32'd36);
        repeat (3) @(negedge i_clk);
        check("arb_bits", 32'(rx_bits[8:1]), 32'h00);
        check("arb_err_cnt", 32'(err_cnt - ec0), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
